tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//  Generates game-update ticks for up to NUM_CH entities (Pac-Man, ghosts, ...) from clock_50, each at its own programmable interval.
//  Ticks queue as per-channel pending bits. A round-robin arbiter issues them one at a time to the game FSM over a valid/ready handshake.
//  Sits between the game controller (configures intervals, consumes ticks) and the per-entity movement logic.
// PARAMETERS
//  NUM_CH  4   number of tick channels (2..8)
//  CNT_W   28  interval/counter width in clock_50 cycles
// PORTS
//  clock_50         in   1              system clock, 50 MHz
//  reset            in   1              asynchronous, active-high; clears all state
//  run              in   1              1: channel counters advance; 0: counters freeze
//  cfg_we           in   1              write strobe for interval config
//  cfg_ch           in   $clog2(NUM_CH) channel index for write
//  cfg_interval     in   CNT_W          new interval in cycles; 0 disables channel
//  clear_overrun    in   1              clears all overrun flags
//  upd_valid        out  1              tick grant outstanding
//  upd_ch           out  $clog2(NUM_CH) channel of outstanding tick
//  upd_ready        in   1              consumer accepts grant
//  overrun          out  NUM_CH         sticky: tick lost (coalesced) on channel
// BEHAVIOUR
//  Reset (async): intervals=0, counters=0, pending=0, upd_valid=0, upd_ch=0, overrun=0, last_grant=NUM_CH-1.
//  Clock/reset: one clock, clock_50. Reset is asynchronous and active-high.
//  Channel counter, per edge with run=1 and interval!=0:
//   - counter==1 (or interval==1): reload interval, raise tick for that cycle.
//   - otherwise counter-1.
//  Tick period is exactly interval cycles.
//  interval==0: counter held 0, no ticks. run=0: counters hold; pending/arbiter still drain.
//  cfg_we: interval[cfg_ch] and counter[cfg_ch] <= cfg_interval; pending[cfg_ch] cleared.
//   - Wins over a same-cycle tick on that channel; no overrun is set.
//   - If upd_valid is up for that channel, the grant stays until the handshake.
//   - cfg_ch>=NUM_CH: write ignored.
//  Pending: a tick sets pending[ch].
//   - Tick while pending[ch]=1 and not being accepted this cycle: overrun[ch]<=1, ticks coalesce.
//  Arbiter: while upd_valid=0 and any pending bit set, select first pending channel searching last_grant+1, +2, ... (mod NUM_CH).
//   - Registers upd_valid=1, upd_ch=sel, last_grant=sel.
//   - Pending bit is not cleared at grant.
//  Handshake: upd_valid/upd_ch stable until upd_valid&&upd_ready.
//   - At that edge: pending[upd_ch] cleared, upd_valid<=0.
//   - A same-edge new tick on that channel keeps pending=1, no overrun.
//   - upd_valid is low for >=1 cycle between grants.
//   - Max throughput: one grant per 2 cycles.
//  Latency: tick at edge N -> upd_valid high after edge N+1 at earliest.
//  clear_overrun: overrun<=0, but a same-cycle overrun set wins for that bit.
//  Counters are CNT_W unsigned; no wrap below 0 (reload at 1).
// STRUCTURE
//  Package tick_pkg: NUM_CH/CNT_W defaults; channel index constants CH_PACMAN=0, CH_GHOST0..; default interval constants.
//  Sub-module tick_channel (one per channel via generate):
//   - Interval reg and down-counter.
//   - Inputs: run, load, load_val. Output: tick pulse.
//  Top level holds pending/overrun vectors, round-robin arbiter, handshake regs.
// TESTING
//  1. Reset, cfg ch0=5, run=1, upd_ready=1:
//     - upd_valid pulses with upd_ch=0 every 5 cycles.
//     - First tick 5 cycles after write.
//  2. ch0..3 all interval=4 written same-phase, upd_ready=1:
//     - Grants in order 0,1,2,3, one per 2 cycles.
//     - No overrun.
//  3. ch1=3, upd_ready=0 for 10 cycles:
//     - single upd_valid (ch1) held stable.
//     - overrun[1]=1.
//     - clear_overrun -> 0.
//  4. ch2=6 running, run=0 for 20 cycles then 1:
//     - No ticks during freeze.
//     - Next tick at remaining count.
//  5. cfg write ch0=8 on the exact cycle ch0 would tick:
//     - No tick, no overrun.
//     - Next tick 8 cycles later.
//  6. Assert reset mid-grant (upd_valid=1):
//     - All outputs 0 immediately (async).
//     - No ticks until reconfigured.

Source files
------------

// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tick_pkg
//  Brief   : Shared sizing defaults, channel indices and default tick intervals
//  Revision: 1.0
// ============================================================================
package tick_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 28;

    localparam int CH_PACMAN = 0;
    localparam int CH_GHOST0 = 1;
    localparam int CH_GHOST1 = 2;
    localparam int CH_GHOST2 = 3;

    // Intervals in clock_50 cycles: 100 Hz for Pac-Man, 80 Hz for the ghosts
    localparam int unsigned IV_PACMAN_DEF = 500_000;
    localparam int unsigned IV_GHOST_DEF  = 625_000;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_scheduler_channel.sv
`default_nettype none
// ============================================================================
//  Module  : tick_channel
//  Brief   : Programmable-interval down-counter producing a one-cycle tick
//  Revision: 1.0
// ============================================================================
module tick_channel #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_active;
    logic             w_expire;

    always_comb begin
        w_active   = run && (interval_q != '0);
        w_expire   = w_active && ((count_q <= CNT_W'(1)) || (interval_q == CNT_W'(1)));
        interval_d = interval_q;
        count_d    = count_q;
        tick       = 1'b0;
        // A configuration write swallows a tick that would fire on the same edge
        if (load) begin
            interval_d = load_val;
            count_d    = load_val;
        end else if (w_expire) begin
            count_d = interval_q;
            tick    = 1'b1;
        end else if (w_active) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_q <= '0;
            count_q    <= '0;
        end else begin
            interval_q <= interval_d;
            count_q    <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tick_scheduler
//  Brief   : Per-entity tick generators with pending queue and round-robin grant
//  Revision: 1.0
// ============================================================================
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic              clear_overrun,
    output logic              upd_valid,
    output logic [CH_W-1:0]   upd_ch,
    input  logic              upd_ready,
    output logic [NUM_CH-1:0] overrun
);

    logic [NUM_CH-1:0] w_tick, w_load, w_accept;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic              upd_valid_q, upd_valid_d;
    logic [CH_W-1:0]   upd_ch_q, upd_ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CH_W-1:0]   w_sel, w_idx;
    logic              w_found;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            // Out-of-range cfg_ch values match no channel, so the write is dropped
            assign w_load[g]   = cfg_we && (cfg_ch == CH_W'(g));
            assign w_accept[g] = upd_valid_q && upd_ready && (upd_ch_q == CH_W'(g));

            tick_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk      (clock_50),
                .rst      (reset),
                .run      (run),
                .load     (w_load[g]),
                .load_val (cfg_interval),
                .tick     (w_tick[g])
            );
        end
    endgenerate

    always_comb begin
        pending_d = pending_q;
        overrun_d = clear_overrun ? '0 : overrun_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_load[i]) begin
                pending_d[i] = 1'b0;
            end else if (w_tick[i]) begin
                if (pending_q[i] && !w_accept[i]) begin
                    overrun_d[i] = 1'b1;
                end
                pending_d[i] = 1'b1;
            end else if (w_accept[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Search starts one past the previous winner so every channel gets a turn
    always_comb begin
        w_sel   = last_grant_q;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_W'(rr_index(int'(last_grant_q), i, NUM_CH));
            if (!w_found && pending_q[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        upd_valid_d  = upd_valid_q;
        upd_ch_d     = upd_ch_q;
        last_grant_d = last_grant_q;
        if (upd_valid_q) begin
            if (upd_ready) begin
                upd_valid_d = 1'b0;
            end
        end else if (w_found) begin
            upd_valid_d  = 1'b1;
            upd_ch_d     = w_sel;
            last_grant_d = w_sel;
        end
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            overrun_q    <= '0;
            upd_valid_q  <= 1'b0;
            upd_ch_q     <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            upd_valid_q  <= upd_valid_d;
            upd_ch_q     <= upd_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign upd_valid = upd_valid_q;
    assign upd_ch    = upd_ch_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tick_scheduler
//  Brief   : Self-checking bench; expected grants (channel, cycle) are queued
//            when stimulus is applied and matched as handshakes occur
//  Revision: 1.0
// ============================================================================
module tb_tick_scheduler;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;

    logic        clock_50      = 1'b0;
    logic        reset         = 1'b1;
    logic        run           = 1'b0;
    logic        cfg_we        = 1'b0;
    logic [1:0]  cfg_ch        = '0;
    logic [27:0] cfg_interval  = '0;
    logic        clear_overrun = 1'b0;
    logic        upd_ready     = 1'b0;
    logic        upd_valid;
    logic [1:0]  upd_ch;
    logic [3:0]  overrun;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    tick_scheduler #(
        .NUM_CH (4),
        .CNT_W  (28)
    ) dut (
        .clock_50      (clock_50),
        .reset         (reset),
        .run           (run),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_interval  (cfg_interval),
        .clear_overrun (clear_overrun),
        .upd_valid     (upd_valid),
        .upd_ch        (upd_ch),
        .upd_ready     (upd_ready),
        .overrun       (overrun)
    );

    always #5 clock_50 = ~clock_50;

    always @(posedge clock_50) cyc <= cyc + 1;

    // Scoreboard: every accepted grant must be the next expected (channel, cycle)
    always @(negedge clock_50) begin
        if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: got ch=%0d at cycle %0d, expected no grant", upd_ch, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(upd_ch) !== mon_e.ch || cyc !== mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL grant_match: got ch=%0d cycle=%0d, expected ch=%0d cycle=%0d",
                             upd_ch, cyc, mon_e.ch, mon_e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push_exp(input int ch, input int c);
        ev_t e;
        e.ch  = ch;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input int ch, input int iv);
        cfg_we       = 1'b1;
        cfg_ch       = 2'(ch);
        cfg_interval = 28'(iv);
        step(1);
        cfg_we       = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        run           = 1'b0;
        cfg_we        = 1'b0;
        cfg_ch        = '0;
        cfg_interval  = '0;
        clear_overrun = 1'b0;
        upd_ready     = 1'b1;
        step(2);
        reset = 1'b0;
        exp_q.delete();
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock_50);
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, expected 0", upd_valid);
        end
        n_checks++;
        if (upd_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ch: got %0d, expected 0", upd_ch);
        end
        n_checks++;
        if (overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_overrun: got %b, expected 0000", overrun);
        end
        run = 1'b1;
        step(10);
        @(negedge clock_50);
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_ticks: got upd_valid=%b, expected 0", upd_valid);
        end
    endtask

    task automatic test_single_channel();
        int c;
        do_reset();
        c   = cyc;
        run = 1'b1;
        push_exp(0, c + 7);
        push_exp(0, c + 12);
        push_exp(0, c + 17);
        cfg_write(0, 5);
        wait_until(c + 8);
        @(negedge clock_50);
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_valid_drop: got %b, expected 0", upd_valid);
        end
        wait_until(c + 19);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_missing: got %0d grants outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        c = cyc;
        cfg_write(0, 4);
        cfg_write(1, 4);
        cfg_write(2, 4);
        cfg_write(3, 4);
        run = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i, c + 9 + 2 * i);
        wait_until(c + 8);
        run = 1'b0;
        wait_until(c + 17);
        @(negedge clock_50);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_missing: got %0d grants outstanding, expected 0", exp_q.size());
        end
        n_checks++;
        if (overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_overrun: got %b, expected 0000", overrun);
        end
    endtask

    task automatic test_backpressure();
        int c;
        do_reset();
        c         = cyc;
        run       = 1'b1;
        upd_ready = 1'b0;
        cfg_write(1, 3);
        for (int k = c + 5; k <= c + 15; k++) begin
            wait_until(k);
            @(negedge clock_50);
            n_checks++;
            if (upd_valid !== 1'b1 || upd_ch !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got valid=%b ch=%0d, expected valid=1 ch=1",
                         k, upd_valid, upd_ch);
            end
        end
        n_checks++;
        if (overrun !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_overrun: got %b, expected 0010", overrun);
        end
        wait_until(c + 16);
        run       = 1'b0;
        upd_ready = 1'b1;
        push_exp(1, c + 16);
        wait_until(c + 17);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        @(negedge clock_50);
        n_checks++;
        if (overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_clear: got %b, expected 0000", overrun);
        end
        n_checks++;
        if (upd_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b outstanding=%0d, expected 0 and 0",
                     upd_valid, exp_q.size());
        end
    endtask

    task automatic test_freeze();
        int c;
        do_reset();
        c   = cyc;
        run = 1'b1;
        push_exp(2, c + 8);
        push_exp(2, c + 34);
        cfg_write(2, 6);
        wait_until(c + 9);
        run = 1'b0;
        wait_until(c + 29);
        run = 1'b1;
        wait_until(c + 37);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL freeze_missing: got %0d grants outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_cfg_collision();
        int c;
        do_reset();
        c   = cyc;
        run = 1'b1;
        push_exp(0, c + 7);
        push_exp(0, c + 20);
        cfg_write(0, 5);
        wait_until(c + 10);
        cfg_write(0, 8);
        wait_until(c + 22);
        @(negedge clock_50);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL collide_missing: got %0d grants outstanding, expected 0", exp_q.size());
        end
        n_checks++;
        if (overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL collide_overrun: got %b, expected 0000", overrun);
        end
    endtask

    task automatic test_async_reset();
        int c;
        do_reset();
        c         = cyc;
        run       = 1'b1;
        upd_ready = 1'b0;
        cfg_write(3, 2);
        wait_until(c + 5);
        @(negedge clock_50);
        n_checks++;
        if (upd_valid !== 1'b1 || upd_ch !== 2'd3 || overrun !== 4'b1000) begin
            n_fail++;
            $display("FAIL areset_pre: got valid=%b ch=%0d ovr=%b, expected 1 3 1000",
                     upd_valid, upd_ch, overrun);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (upd_valid !== 1'b0 || upd_ch !== 2'd0 || overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_now: got valid=%b ch=%0d ovr=%b, expected 0 0 0000",
                     upd_valid, upd_ch, overrun);
        end
        step(1);
        reset     = 1'b0;
        run       = 1'b1;
        upd_ready = 1'b1;
        step(20);
        @(negedge clock_50);
        n_checks++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_quiet: got valid=%b, expected 0", upd_valid);
        end
        step(1);
        c = cyc;
        push_exp(1, c + 4);
        cfg_write(1, 2);
        wait_until(c + 5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL areset_reconfig: got %0d grants outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_freeze();
        test_cfg_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
